// File: rtl/uart_pkg.sv
// Shared UART definitions for the rx and tx byte engines.
// Provides the frame state encoding, the data width and the
// cycles-per-bit helper used to size bit timers.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  // Receiver frame states
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  // Whole clock cycles per serial bit (integer division)
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_byte_receiver_if.sv
// Serial-in / byte-out bundle of the UART byte receiver.
// Signals:
//   rx          serial line, idle high (driven by the line side)
//   data_out    last correctly framed byte
//   data_valid  one-cycle pulse when data_out updates
//   frame_error one-cycle pulse on a low stop bit
//   busy        receiver is inside a frame
// Modports: slave = receiver side, master = line/consumer side.
interface uart_byte_receiver_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 frame_error;
  logic                 busy;

  modport master (
    output rx,
    input  data_out,
    input  data_valid,
    input  frame_error,
    input  busy
  );

  modport slave (
    input  rx,
    output data_out,
    output data_valid,
    output frame_error,
    output busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset, loads RESET_VAL into both flops
//   d    asynchronous input
//   q    synchronised output (2 cycles of latency)
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART byte receiver, LSB first, idle-high line.
// Samples each bit at its centre with a clock-derived bit timer and
// reports framing errors instead of forwarding bad bytes.
// Ports:
//   clk  system clock (rising edge)
//   rst  synchronous active-high reset
//   bus  uart_byte_receiver_if.slave: rx in; data_out, data_valid,
//        frame_error, busy out (all registered)
module uart_byte_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 10_000_000,
  parameter int unsigned BAUD_RATE = 115_200
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_byte_receiver_if.slave  bus
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned TIMER_W      = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W        = 3;

  localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(HALF_BIT - 1);
  localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(DATA_BITS - 1);

  // Too few cycles per bit leaves no room to find the bit centre
  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $fatal(1, "uart_byte_receiver: CLKS_PER_BIT must be at least 4");
  end

  logic rx_s;

  rx_state_t            state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 error_q, error_d;
  logic                 busy_q;

  // Line synchroniser, resets to the idle level
  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      busy_q    <= (state_d != IDLE);
    end
  end

  // Next-state and datapath decode
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    error_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        timer_d   = '0;
        bit_idx_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      // Re-check the line at the start-bit centre to reject glitches
      START: begin
        if (timer_q == HALF_LAST) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      // LSB arrives first, so shift right and insert at the MSB
      DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d   = '0;
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == IDX_LAST) begin
            state_d = STOP;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      // Decision at stop-bit centre; returning to IDLE here leaves half a
      // bit of slack to catch a back-to-back start edge
      STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            error_d = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      // A held-low line (break) must not look like a new start bit
      WAIT_HIGH: begin
        timer_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign bus.data_out    = data_q;
  assign bus.data_valid  = valid_q;
  assign bus.frame_error = error_q;
  assign bus.busy        = busy_q;

endmodule
